// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter feeding a registered N:1 data mux with valid/ready output
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid[N]         per-requester valid
//   in_data[N*W]        packed words, requester i at [i*W +: W]
//   in_ready[N]         one-hot grant, combinational
//   out_valid/out_data  registered winning word
//   out_sel             index of the requester that supplied out_data
//   out_ready           downstream accept
//   in_last/out_last    packet framing, only with ARB_PACKET_LOCK_EN defined
module rr_mux_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_ready,
`ifdef ARB_PACKET_LOCK_EN
    input  logic [N-1:0]         in_last,
    output logic                 out_last,
`endif
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic                 out_ready
);
    localparam int SW = $clog2(N);
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr;
    logic [SW-1:0] win;
    logic          any;
    logic          can_accept;
    logic          xfer;
    logic [W-1:0]  win_data;
    // Scan from farthest to nearest so the first valid after ptr is the last assignment.
    always_comb begin
        rr = ptr;
        for (int k = N; k >= 1; k--)
            if (in_valid[(int'(ptr) + k) % N]) rr = SW'((int'(ptr) + k) % N);
    end
`ifdef ARB_PACKET_LOCK_EN
    logic lock;
    // ptr already holds the locked requester, so a locked grant is simply ptr.
    assign win = lock ? ptr : rr;
    assign any = lock ? in_valid[ptr] : |in_valid;
`else
    assign win = rr;
    assign any = |in_valid;
`endif
    assign can_accept = ~out_valid | out_ready;
    assign in_ready   = (!rst && can_accept && any) ? N'(1) << win : '0;
    assign xfer       = |in_ready;
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++)
            if (SW'(i) == win) win_data = in_data[i*W +: W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
`ifdef ARB_PACKET_LOCK_EN
            lock      <= 1'b0;
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win;
            ptr       <= win;
`ifdef ARB_PACKET_LOCK_EN
            lock      <= ~in_last[win];
            out_last  <= in_last[win];
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
